// File: rtl/lsm_normal_accum.sv
// lsm_normal_accum
// Streams (x, y) regression samples for one Longstaff-Schwartz exercise step
// and accumulates the power sums of the quadratic least-squares normal
// equations. At the end of each batch it emits the augmented 3x4 matrix as a
// flat 12-word vector with a one-cycle valid_out pulse. That pulse is meant to
// drive the regression solver's mat_flat/valid_in input.
//
// Optional build macro: ITM_FILTER_EN
//   When defined, accepted samples with in_itm=0 complete the handshake and
//   still honour in_last, but they do not contribute to any sum or the count.
//   When undefined, in_itm is ignored.
//
// mat_flat packing: entry k (row-major, k = row*4 + col) is at
// mat_flat[k*WIDTH +: WIDTH]. Entry 0 is therefore in the least significant
// word.
//
// The WIDTH/QFRAC defaults are the project Q16.16 format (FP_WIDTH/FP_QFRAC).
module lsm_normal_accum #(
    parameter int WIDTH       = 32,
    parameter int QFRAC       = 16,
    parameter int ACC_WIDTH   = 48,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_x,
    input  logic [WIDTH-1:0]        in_y,
    input  logic                    in_itm,
    input  logic                    in_last,
    output logic                    valid_out,
    output logic [12*WIDTH-1:0]     mat_flat,
    output logic [COUNT_WIDTH-1:0]  count_out,
    output logic                    batch_empty
);

    // Products are formed at twice the accumulator width. This keeps the
    // product exact before the shift and the saturation.
    localparam int PW = 2 * ACC_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [PW-1:0] ACC_MAX_P = {{(PW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] ACC_MIN_P = {{(PW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX_A = {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN_A = {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] OUT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] OUT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Accumulator slots
    localparam int SX = 0, SX2 = 1, SX3 = 2, SX4 = 3, SY = 4, SXY = 5, SX2Y = 6;

    typedef enum logic [1:0] {ST_ACCUM, ST_DRAIN, ST_EMIT} state_t;

    function automatic logic signed [ACC_WIDTH-1:0] ext_acc(input logic [WIDTH-1:0] v);
        return {{(ACC_WIDTH-WIDTH){v[WIDTH-1]}}, v};
    endfunction

    function automatic logic signed [PW-1:0] wide(input logic signed [ACC_WIDTH-1:0] v);
        return {{(PW-ACC_WIDTH){v[ACC_WIDTH-1]}}, v};
    endfunction

    // Q-format rescale of a full product: the arithmetic shift floors toward
    // minus infinity, and the result is then clamped to the accumulator range.
    function automatic logic signed [ACC_WIDTH-1:0] sat_prod(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] s;
        s = v >>> QFRAC;
        if (s > ACC_MAX_P)
            return ACC_MAX;
        else if (s < ACC_MIN_P)
            return ACC_MIN;
        else
            return s[ACC_WIDTH-1:0];
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] sat_add(input logic signed [ACC_WIDTH-1:0] a,
                                                             input logic signed [ACC_WIDTH-1:0] b);
        logic [ACC_WIDTH:0] s;
        s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
            return s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        else
            return s[ACC_WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] sat_out(input logic signed [ACC_WIDTH-1:0] v);
        if (v > OUT_MAX_A)
            return OUT_MAX;
        else if (v < OUT_MIN_A)
            return OUT_MIN;
        else
            return v[WIDTH-1:0];
    endfunction

    state_t                          state_reg;
    logic                            in_ready_reg;
    logic                            valid_out_reg;
    logic [WIDTH-1:0]                mat_reg [12];
    logic [COUNT_WIDTH-1:0]          count_out_reg;
    logic                            batch_empty_reg;

    logic                            p1_valid_reg, p1_acc_reg, p1_last_reg;
    logic [WIDTH-1:0]                p1_x_reg, p1_y_reg;
    logic                            p2_valid_reg, p2_acc_reg, p2_last_reg;
    logic signed [ACC_WIDTH-1:0]     p2_x_reg, p2_y_reg, p2_x2_reg, p2_xy_reg;
    logic                            p3_valid_reg, p3_acc_reg, p3_last_reg;
    logic signed [ACC_WIDTH-1:0]     p3_x_reg, p3_y_reg, p3_x2_reg, p3_xy_reg;
    logic signed [ACC_WIDTH-1:0]     p3_x3_reg, p3_x4_reg, p3_x2y_reg;
    logic                            p4_done_reg;

    logic signed [ACC_WIDTH-1:0]     acc_reg [7];
    logic signed [ACC_WIDTH-1:0]     acc_inc [7];
    logic [COUNT_WIDTH-1:0]          count_reg;
    logic signed [ACC_WIDTH-1:0]     entry_acc [12];
    logic [ACC_WIDTH-1:0]            s1_acc;

    logic accept;
    logic sample_en;
    logic emit_go;

    assign accept = in_valid & in_ready_reg;

`ifdef ITM_FILTER_EN
    assign sample_en = in_itm;
`else
    logic unused_itm;
    assign unused_itm = in_itm;
    assign sample_en  = 1'b1;
`endif

    // The last sample has reached the accumulators and the pipeline is empty.
    assign emit_go = (state_reg == ST_DRAIN) && p4_done_reg;

    // Three-stage product pipeline: P1 capture, P2 squares, P3 cubes and quartics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_valid_reg <= 1'b0; p1_acc_reg <= 1'b0; p1_last_reg <= 1'b0;
            p1_x_reg     <= '0;   p1_y_reg   <= '0;
            p2_valid_reg <= 1'b0; p2_acc_reg <= 1'b0; p2_last_reg <= 1'b0;
            p2_x_reg     <= '0;   p2_y_reg   <= '0;
            p2_x2_reg    <= '0;   p2_xy_reg  <= '0;
            p3_valid_reg <= 1'b0; p3_acc_reg <= 1'b0; p3_last_reg <= 1'b0;
            p3_x_reg     <= '0;   p3_y_reg   <= '0;
            p3_x2_reg    <= '0;   p3_xy_reg  <= '0;
            p3_x3_reg    <= '0;   p3_x4_reg  <= '0;   p3_x2y_reg <= '0;
            p4_done_reg  <= 1'b0;
        end else begin
            p1_valid_reg <= accept;
            p1_acc_reg   <= accept & sample_en;
            p1_last_reg  <= accept & in_last;
            if (accept) begin
                p1_x_reg <= in_x;
                p1_y_reg <= in_y;
            end

            p2_valid_reg <= p1_valid_reg;
            p2_acc_reg   <= p1_acc_reg;
            p2_last_reg  <= p1_last_reg;
            p2_x_reg     <= ext_acc(p1_x_reg);
            p2_y_reg     <= ext_acc(p1_y_reg);
            p2_x2_reg    <= sat_prod(wide(ext_acc(p1_x_reg)) * wide(ext_acc(p1_x_reg)));
            p2_xy_reg    <= sat_prod(wide(ext_acc(p1_x_reg)) * wide(ext_acc(p1_y_reg)));

            p3_valid_reg <= p2_valid_reg;
            p3_acc_reg   <= p2_acc_reg;
            p3_last_reg  <= p2_last_reg;
            p3_x_reg     <= p2_x_reg;
            p3_y_reg     <= p2_y_reg;
            p3_x2_reg    <= p2_x2_reg;
            p3_xy_reg    <= p2_xy_reg;
            p3_x3_reg    <= sat_prod(wide(p2_x2_reg) * wide(p2_x_reg));
            p3_x4_reg    <= sat_prod(wide(p2_x2_reg) * wide(p2_x2_reg));
            p3_x2y_reg   <= sat_prod(wide(p2_x2_reg) * wide(p2_y_reg));

            p4_done_reg  <= p3_valid_reg & p3_last_reg;
        end
    end

    assign acc_inc[SX]   = p3_x_reg;
    assign acc_inc[SX2]  = p3_x2_reg;
    assign acc_inc[SX3]  = p3_x3_reg;
    assign acc_inc[SX4]  = p3_x4_reg;
    assign acc_inc[SY]   = p3_y_reg;
    assign acc_inc[SXY]  = p3_xy_reg;
    assign acc_inc[SX2Y] = p3_x2y_reg;

    // P4: saturating accumulation. The emit cycle clears everything for the next batch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 7; i++) acc_reg[i] <= '0;
            count_reg <= '0;
        end else if (emit_go) begin
            for (int i = 0; i < 7; i++) acc_reg[i] <= '0;
            count_reg <= '0;
        end else if (p3_valid_reg && p3_acc_reg) begin
            for (int i = 0; i < 7; i++) acc_reg[i] <= sat_add(acc_reg[i], acc_inc[i]);
            if (count_reg != {COUNT_WIDTH{1'b1}})
                count_reg <= count_reg + 1'b1;
        end
    end

    // S1 is the sample count expressed in the fixed-point format.
    assign s1_acc = {{(ACC_WIDTH-COUNT_WIDTH){1'b0}}, count_reg} << QFRAC;

    assign entry_acc[0]  = s1_acc;
    assign entry_acc[1]  = acc_reg[SX];
    assign entry_acc[2]  = acc_reg[SX2];
    assign entry_acc[3]  = acc_reg[SY];
    assign entry_acc[4]  = acc_reg[SX];
    assign entry_acc[5]  = acc_reg[SX2];
    assign entry_acc[6]  = acc_reg[SX3];
    assign entry_acc[7]  = acc_reg[SXY];
    assign entry_acc[8]  = acc_reg[SX2];
    assign entry_acc[9]  = acc_reg[SX3];
    assign entry_acc[10] = acc_reg[SX4];
    assign entry_acc[11] = acc_reg[SX2Y];

    // Batch control: accept until in_last, drain the pipeline, then emit one matrix.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_ACCUM;
            in_ready_reg    <= 1'b1;
            valid_out_reg   <= 1'b0;
            for (int i = 0; i < 12; i++) mat_reg[i] <= '0;
            count_out_reg   <= '0;
            batch_empty_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_ACCUM: begin
                    if (accept && in_last) begin
                        state_reg    <= ST_DRAIN;
                        in_ready_reg <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (p4_done_reg) begin
                        state_reg       <= ST_EMIT;
                        valid_out_reg   <= 1'b1;
                        for (int i = 0; i < 12; i++) mat_reg[i] <= sat_out(entry_acc[i]);
                        count_out_reg   <= count_reg;
                        batch_empty_reg <= (count_reg == '0);
                    end
                end
                ST_EMIT: begin
                    state_reg     <= ST_ACCUM;
                    valid_out_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                end
                default: begin
                    state_reg     <= ST_ACCUM;
                    valid_out_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 12; gi++) begin : g_mat
            assign mat_flat[gi*WIDTH +: WIDTH] = mat_reg[gi];
        end
    endgenerate

    assign in_ready    = in_ready_reg;
    assign valid_out   = valid_out_reg;
    assign count_out   = count_out_reg;
    assign batch_empty = batch_empty_reg;

endmodule

// File: tb/tb_lsm_normal_accum.sv
// Directed testbench for lsm_normal_accum.
// Each scenario task drives its stimulus and checks the results inline.
// Expected matrices are hand-computed Q16.16 power sums.
module tb_lsm_normal_accum;

    localparam int W = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_itm = 1'b1;
    logic            in_last = 1'b0;
    logic [W-1:0]    in_x = '0;
    logic [W-1:0]    in_y = '0;
    logic            in_ready;
    logic            valid_out;
    logic [12*W-1:0] mat_flat;
    logic [15:0]     count_out;
    logic            batch_empty;

    int tests = 0;
    int fails = 0;

    lsm_normal_accum dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_itm     (in_itm),
        .in_last    (in_last),
        .valid_out  (valid_out),
        .mat_flat   (mat_flat),
        .count_out  (count_out),
        .batch_empty(batch_empty)
    );

    always #5 clk = ~clk;

    // Build the expected row-major augmented matrix from the eight distinct sums.
    function automatic logic [12*W-1:0] mk_mat(input logic [W-1:0] s1, sx, sx2, sx3, sx4,
                                               input logic [W-1:0] sy, sxy, sx2y);
        logic [W-1:0]    e [12];
        logic [12*W-1:0] m;
        e = '{s1, sx, sx2, sy, sx, sx2, sx3, sxy, sx2, sx3, sx4, sx2y};
        m = '0;
        for (int k = 0; k < 12; k++) m[k*W +: W] = e[k];
        return m;
    endfunction

    // Offer one sample and hold it until an edge accepts it (bounded).
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic itm, input logic last);
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1; in_x = x; in_y = y; in_itm = itm; in_last = last;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        tests++;
        if (guard >= 20) begin
            fails++;
            $display("[TB] FAIL send_ready: in_ready=%0b required 1 within 20 cycles", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0; in_last = 1'b0;
        $display("[TB] sample x=%h y=%h itm=%0b last=%0b", x, y, itm, last);
    endtask

    // After the last accept, count edges until valid_out appears and note whether in_ready stayed low.
    task automatic wait_emit(output int lat, output bit ready_low);
        lat = -1;
        ready_low = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (in_ready) ready_low = 1'b0;
            if (valid_out) begin
                lat = n;
                break;
            end
        end
        $display("[TB] emit latency=%0d count=%0d empty=%0b", lat, count_out, batch_empty);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; in_itm = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready: got %0b want 1", in_ready); end
        tests++;
        if (valid_out !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid_out: got %0b want 0", valid_out); end
        tests++;
        if (mat_flat !== '0) begin fails++; $display("[TB] FAIL reset_mat_flat: got %h want 0", mat_flat); end
        tests++;
        if (count_out !== 16'd0) begin fails++; $display("[TB] FAIL reset_count: got %0d want 0", count_out); end
        tests++;
        if (batch_empty !== 1'b0) begin fails++; $display("[TB] FAIL reset_empty: got %0b want 0", batch_empty); end
    endtask

    task automatic test_basic_sum();
        int lat; bit rl; logic [12*W-1:0] exp_m;
        exp_m = mk_mat(32'h0003_0000, 32'h0003_0000, 32'h0003_0000, 32'h0003_0000, 32'h0003_0000,
                       32'h0006_0000, 32'h0006_0000, 32'h0006_0000);
        send(32'h0001_0000, 32'h0002_0000, 1'b1, 1'b0);
        send(32'h0001_0000, 32'h0002_0000, 1'b1, 1'b0);
        send(32'h0001_0000, 32'h0002_0000, 1'b1, 1'b1);
        wait_emit(lat, rl);
        tests++;
        if (lat !== 4) begin fails++; $display("[TB] FAIL basic_latency: got %0d want 4", lat); end
        tests++;
        if (!rl) begin fails++; $display("[TB] FAIL basic_ready_low: in_ready rose during drain, want 0"); end
        tests++;
        if (mat_flat !== exp_m) begin fails++; $display("[TB] FAIL basic_mat: got %h want %h", mat_flat, exp_m); end
        tests++;
        if (count_out !== 16'd3) begin fails++; $display("[TB] FAIL basic_count: got %0d want 3", count_out); end
        tests++;
        if (batch_empty !== 1'b0) begin fails++; $display("[TB] FAIL basic_empty: got %0b want 0", batch_empty); end
        @(negedge clk);
        tests++;
        if (valid_out !== 1'b0) begin fails++; $display("[TB] FAIL basic_pulse: valid_out=%0b want 0", valid_out); end
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL basic_ready_back: got %0b want 1", in_ready); end
        repeat (3) @(negedge clk);
        tests++;
        if (mat_flat !== exp_m) begin fails++; $display("[TB] FAIL basic_hold: got %h want %h", mat_flat, exp_m); end
    endtask

    task automatic test_signed_mix();
        int lat; bit rl; logic [12*W-1:0] exp_m;
        exp_m = mk_mat(32'h0002_0000, 32'h0001_0000, 32'h0005_0000, 32'h0007_0000, 32'h0011_0000,
                       32'h0004_0000, 32'hFFFF_0000, 32'h0007_0000);
        send(32'h0002_0000, 32'h0001_0000, 1'b1, 1'b0);
        send(32'hFFFF_0000, 32'h0003_0000, 1'b1, 1'b1);
        wait_emit(lat, rl);
        tests++;
        if (lat !== 4) begin fails++; $display("[TB] FAIL signed_latency: got %0d want 4", lat); end
        tests++;
        if (mat_flat !== exp_m) begin fails++; $display("[TB] FAIL signed_mat: got %h want %h", mat_flat, exp_m); end
        tests++;
        if (count_out !== 16'd2) begin fails++; $display("[TB] FAIL signed_count: got %0d want 2", count_out); end
    endtask

    // in_last with in_itm=0 on the first edge after reset.
    task automatic test_itm_first();
        int lat; bit rl; logic [12*W-1:0] exp_m;
        logic [15:0] exp_cnt; logic exp_empty;
        rst_n = 1'b0;
        in_valid = 1'b0; in_last = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; in_x = 32'h0001_0000; in_y = 32'h0001_0000; in_itm = 1'b0; in_last = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; in_last = 1'b0; in_itm = 1'b1;
        $display("[TB] sample x=00010000 y=00010000 itm=0 last=1 (first edge after reset)");
`ifdef ITM_FILTER_EN
        exp_m = '0; exp_cnt = 16'd0; exp_empty = 1'b1;
`else
        exp_m = mk_mat(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
                       32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
        exp_cnt = 16'd1; exp_empty = 1'b0;
`endif
        wait_emit(lat, rl);
        tests++;
        if (lat !== 4) begin fails++; $display("[TB] FAIL itm_latency: got %0d want 4", lat); end
        tests++;
        if (mat_flat !== exp_m) begin fails++; $display("[TB] FAIL itm_mat: got %h want %h", mat_flat, exp_m); end
        tests++;
        if (count_out !== exp_cnt) begin fails++; $display("[TB] FAIL itm_count: got %0d want %0d", count_out, exp_cnt); end
        tests++;
        if (batch_empty !== exp_empty) begin fails++; $display("[TB] FAIL itm_empty: got %0b want %0b", batch_empty, exp_empty); end
    endtask

    task automatic test_saturation();
        int lat; bit rl; logic [12*W-1:0] exp_m;
        exp_m = mk_mat(32'h0001_0000, 32'h0010_0000, 32'h0100_0000, 32'h1000_0000, 32'h7FFF_FFFF,
                       32'h0001_0000, 32'h0010_0000, 32'h0100_0000);
        send(32'h0010_0000, 32'h0001_0000, 1'b1, 1'b1);
        wait_emit(lat, rl);
        tests++;
        if (mat_flat[10*W +: W] !== 32'h7FFF_FFFF) begin
            fails++; $display("[TB] FAIL sat_sx4: got %h want 7fffffff", mat_flat[10*W +: W]);
        end
        tests++;
        if (mat_flat !== exp_m) begin fails++; $display("[TB] FAIL sat_mat: got %h want %h", mat_flat, exp_m); end
    endtask

    task automatic test_mid_reset();
        int lat; bit rl; logic [12*W-1:0] exp_m;
        exp_m = mk_mat(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
                       32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
        send(32'h0003_0000, 32'h0002_0000, 1'b1, 1'b0);
        send(32'h0005_0000, 32'h0004_0000, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] mid-batch reset pulse");
        send(32'h0001_0000, 32'h0001_0000, 1'b1, 1'b1);
        wait_emit(lat, rl);
        tests++;
        if (count_out !== 16'd1) begin fails++; $display("[TB] FAIL midrst_count: got %0d want 1", count_out); end
        tests++;
        if (mat_flat !== exp_m) begin fails++; $display("[TB] FAIL midrst_mat: got %h want %h", mat_flat, exp_m); end
    endtask

    // in_valid stays high through drain and emit, and x changes every cycle.
    task automatic test_back_to_back();
        int lat; bit rl; bit ready_ok;
        logic [12*W-1:0] exp1, exp2;
        exp1 = mk_mat(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
                      32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
        exp2 = mk_mat(32'h0001_0000, 32'h0007_0000, 32'h0031_0000, 32'h0157_0000, 32'h0961_0000,
                      32'h0001_0000, 32'h0007_0000, 32'h0031_0000);
        @(negedge clk);
        in_valid = 1'b1; in_x = 32'h0001_0000; in_y = 32'h0001_0000; in_itm = 1'b1; in_last = 1'b1;
        @(posedge clk);
        $display("[TB] sample x=00010000 y=00010000 itm=1 last=1 (b2b batch 1)");
        ready_ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (in_ready) ready_ok = 1'b0;
            if (k == 4) begin
                tests++;
                if (valid_out !== 1'b1) begin fails++; $display("[TB] FAIL b2b_valid1: got %0b want 1", valid_out); end
                tests++;
                if (mat_flat !== exp1) begin fails++; $display("[TB] FAIL b2b_mat1: got %h want %h", mat_flat, exp1); end
                tests++;
                if (count_out !== 16'd1) begin fails++; $display("[TB] FAIL b2b_count1: got %0d want 1", count_out); end
            end
            in_x = (k + 2) << 16;
        end
        tests++;
        if (!ready_ok) begin fails++; $display("[TB] FAIL b2b_ready_low: in_ready rose early, want 0"); end
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL b2b_ready_back: got %0b want 1", in_ready); end
        in_x = 32'h0007_0000;
        @(posedge clk);
        #1 in_valid = 1'b0; in_last = 1'b0;
        $display("[TB] sample x=00070000 y=00010000 itm=1 last=1 (b2b batch 2)");
        wait_emit(lat, rl);
        tests++;
        if (lat !== 4) begin fails++; $display("[TB] FAIL b2b_latency2: got %0d want 4", lat); end
        tests++;
        if (count_out !== 16'd1) begin fails++; $display("[TB] FAIL b2b_count2: got %0d want 1", count_out); end
        tests++;
        if (mat_flat !== exp2) begin fails++; $display("[TB] FAIL b2b_mat2: got %h want %h", mat_flat, exp2); end
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_signed_mix();
        test_itm_first();
        test_saturation();
        test_mid_reset();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
